// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: walks the PC through instruction memory and delivers one instruction
// per handshake. Redirects (branch/jump/jalr) arriving mid-request are deferred to the ack.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_valid,
  input  logic [2:0]  redirect_op,
  input  logic [31:0] br_pc,
  input  logic [31:0] imm,
  input  logic [31:0] aluout,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;
  localparam logic [1:0] StHalt = 2'd3;

  localparam logic [2:0] OpBranch = 3'b001;
  localparam logic [2:0] OpJump   = 3'b010;
  localparam logic [2:0] OpJalr   = 3'b100;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        imem_req_q, imem_req_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        fetch_err_q, fetch_err_d;

  // Redirect decode: only the three legal op codes produce a redirect.
  logic        rd_take;
  logic [31:0] rd_target;
  logic        rd_misaligned;

  always_comb begin
    rd_take   = 1'b0;
    rd_target = br_pc + imm;
    case (redirect_op)
      OpBranch, OpJump: begin
        rd_take   = redirect_valid;
        rd_target = br_pc + imm;
      end
      OpJalr: begin
        rd_take   = redirect_valid;
        rd_target = {aluout[31:1], 1'b0};
      end
      default: rd_take = 1'b0;
    endcase
  end

  assign rd_misaligned = (rd_target[1:0] != 2'b00);

  // Target applied on the ack cycle: the live redirect wins over a deferred one.
  logic [31:0] ack_target;
  logic        ack_redirect;
  logic        ack_misaligned;
  logic [31:0] pc_plus4;

  assign ack_redirect   = rd_take | pend_valid_q;
  assign ack_target     = rd_take ? rd_target : pend_target_q;
  assign ack_misaligned = (ack_target[1:0] != 2'b00);
  assign pc_plus4       = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    inst_valid_d  = inst_valid_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    fetch_err_d   = fetch_err_q;

    case (state_q)
      StIdle, StHold: begin
        if (rd_take) begin
          inst_valid_d = 1'b0;
          if (rd_misaligned) begin
            fetch_err_d = 1'b1;
            state_d     = StHalt;
          end else begin
            pc_d    = rd_target;
            state_d = StReq;
          end
        end else if (state_q == StIdle || !stall) begin
          inst_valid_d = 1'b0;
          state_d      = StReq;
        end
      end
      StReq: begin
        if (imem_ack) begin
          pend_valid_d = 1'b0;
          if (ack_redirect) begin
            inst_valid_d = 1'b0;
            if (ack_misaligned) begin
              fetch_err_d = 1'b1;
              state_d     = StHalt;
            end else begin
              pc_d = ack_target;
            end
          end else begin
            inst_d       = imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_plus4;
            state_d      = StHold;
          end
        end else if (rd_take) begin
          // Address must stay stable until ack, so the redirect waits here.
          pend_valid_d  = 1'b1;
          pend_target_d = rd_target;
        end
      end
      StHalt: begin
        inst_valid_d = 1'b0;
        fetch_err_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    imem_req_d = (state_d == StReq);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      imem_req_q    <= 1'b0;
      inst_valid_q  <= 1'b0;
      inst_q        <= 32'h0;
      inst_pc_q     <= 32'h0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      imem_req_q    <= imem_req_d;
      inst_valid_q  <= inst_valid_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural fetch model.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect_valid;
  logic [2:0]  redirect_op;
  logic [31:0] br_pc, imm, aluout;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic        fetch_err;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .redirect_valid (redirect_valid),
    .redirect_op    (redirect_op),
    .br_pc          (br_pc),
    .imm            (imm),
    .aluout         (aluout),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_err      (fetch_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a fetch is outstanding, an instruction is held, or the core is halted.
  bit          m_fetching, m_valid, m_halt, m_pend;
  logic [31:0] m_pc, m_inst, m_ipc, m_ptgt;
  bit          has_rd;
  logic [31:0] tgt, use_tgt;

  always @(posedge clk) begin
    has_rd = redirect_valid && (redirect_op == 3'b001 || redirect_op == 3'b010 ||
                                redirect_op == 3'b100);
    tgt = (redirect_op == 3'b100) ? (aluout & 32'hFFFF_FFFE) : (br_pc + imm);
    if (!rstn) begin
      m_pc = 32'h0; m_fetching = 0; m_valid = 0; m_halt = 0; m_pend = 0;
      m_inst = 32'h0; m_ipc = 32'h0; m_ptgt = 32'h0;
    end else if (m_halt) begin
      m_valid = 0;
    end else if (m_fetching) begin
      if (imem_ack) begin
        if (has_rd || m_pend) begin
          use_tgt = has_rd ? tgt : m_ptgt;
          m_pend = 0;
          if (use_tgt % 4 != 0) begin
            m_halt = 1; m_fetching = 0;
          end else begin
            m_pc = use_tgt;
          end
        end else begin
          m_inst = imem_rdata; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 4; m_fetching = 0;
        end
      end else if (has_rd) begin
        m_pend = 1; m_ptgt = tgt;
      end
    end else if (has_rd) begin
      m_valid = 0;
      if (tgt % 4 != 0) m_halt = 1;
      else begin m_pc = tgt; m_fetching = 1; end
    end else if (!m_valid || !stall) begin
      m_valid = 0; m_fetching = 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("imem_req", imem_req, m_fetching);
      chk("inst_valid", inst_valid, m_valid);
      chk("fetch_err", fetch_err, m_halt);
      if (m_fetching) chk("imem_addr", imem_addr, m_pc);
      if (m_valid) begin
        chk("inst", inst, m_inst);
        chk("inst_pc", inst_pc, m_ipc);
      end
    end
  end

  task automatic clr();
    redirect_valid = 0; redirect_op = 3'b000; br_pc = 0; imm = 0; aluout = 0;
    stall = 0; imem_ack = 0; imem_rdata = 0;
  endtask

  task automatic redir(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] off,
                       input logic [31:0] alu);
    redirect_valid = 1; redirect_op = op; br_pc = pc; imm = off; aluout = alu;
  endtask

  initial begin
    clr();
    rstn = 0;
    repeat (2) @(negedge clk);
    check_en = 1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);

    // Reset release, ack two cycles after request
    rstn = 1;
    @(negedge clk);
    chk("r33_req", imem_req, 1);
    chk("r33_addr", imem_addr, 32'h0);
    @(negedge clk);
    chk("r33_addr_wait", imem_addr, 32'h0);
    imem_ack = 1; imem_rdata = 32'hA5A5_0001; stall = 1;
    @(negedge clk);
    imem_ack = 0;
    chk("r33_valid", inst_valid, 1);
    chk("r33_inst_pc", inst_pc, 32'h0);
    chk("r33_inst", inst, 32'hA5A5_0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("r34_inst_stable", inst, 32'hA5A5_0001);
      chk("r34_req_low", imem_req, 0);
    end
    stall = 0;
    @(negedge clk);
    chk("r34_next_addr", imem_addr, 32'h4);
    chk("r34_next_req", imem_req, 1);

    // Redirect on the ack cycle moves pc to 0x10
    redir(3'b010, 32'h0, 32'h10, 32'h0); imem_ack = 1; imem_rdata = 32'hDEAD_0000;
    @(negedge clk);
    clr();
    chk("r35_pc10", imem_addr, 32'h10);
    redir(3'b010, 32'h8, 32'h20, 32'h0);
    @(negedge clk);
    clr();
    chk("r35_hold1", imem_addr, 32'h10);
    @(negedge clk);
    chk("r35_hold2", imem_addr, 32'h10);
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    clr();
    chk("r35_discard", inst_valid, 0);
    chk("r35_addr", imem_addr, 32'h28);

    imem_ack = 1; imem_rdata = 32'h0000_1234; stall = 1;
    @(negedge clk);
    clr(); stall = 1;
    chk("r36_valid", inst_valid, 1);
    chk("r36_inst_pc", inst_pc, 32'h28);
    redir(3'b100, 32'h0, 32'h0, 32'h101);
    @(negedge clk);
    clr();
    chk("r36_drop", inst_valid, 0);
    chk("r36_addr", imem_addr, 32'h100);

    // Wrap at the top of the address space
    redir(3'b010, 32'hFFFF_FFF0, 32'hC, 32'h0); imem_ack = 1;
    @(negedge clk);
    clr();
    chk("r38_top", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1; imem_rdata = 32'h0000_0077;
    @(negedge clk);
    clr();
    chk("r38_inst_pc", inst_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("r38_wrap", imem_addr, 32'h0);
    chk("r38_err", fetch_err, 0);

    // Misaligned branch halts
    imem_ack = 1; stall = 1;
    @(negedge clk);
    clr();
    redir(3'b001, 32'h0, 32'h6, 32'h0);
    @(negedge clk);
    clr();
    chk("r37_err", fetch_err, 1);
    chk("r37_req", imem_req, 0);
    chk("r37_valid", inst_valid, 0);
    for (int i = 0; i < 3; i++) begin
      redir(3'b010, 32'h0, 32'h40, 32'h0); imem_ack = 1;
      @(negedge clk);
      chk("r37_halted", fetch_err, 1);
      chk("r37_no_req", imem_req, 0);
    end
    clr();
    rstn = 0;
    @(negedge clk);
    chk("r37_reset_err", fetch_err, 0);

    // Reset with a concurrent ack abandons the request
    rstn = 1;
    @(negedge clk);
    chk("r32_req", imem_req, 1);
    rstn = 0; imem_ack = 1; imem_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("r32_valid", inst_valid, 0);
    chk("r32_req_low", imem_req, 0);
    clr();
    rstn = 1;

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rstn = ($urandom_range(0, 199) != 0) && !(m_halt && $urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 9) < 4);
      imem_ack = $urandom_range(0, 1);
      imem_rdata = $urandom;
      redirect_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 5))
        0: redirect_op = 3'b001;
        1: redirect_op = 3'b010;
        2: redirect_op = 3'b100;
        default: redirect_op = 3'($urandom_range(0, 7));
      endcase
      br_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      imm = ($urandom_range(0, 15) == 0) ? ($urandom & 32'hFF) : ($urandom & 32'h3FC);
      aluout = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFD);
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
